// File: rtl/add16_serial_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and digit width.
package add16_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add16_serial_add4bit.sv
// Combinational 4-bit adder used once per nibble by the serial adder.
module add4bit
  import add16_serial_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/add16_serial.sv
// Nibble-serial adder: one 4-bit digit per cycle, low nibble first, result held until the next start.
module add16_serial
  import add16_serial_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state, state_nxt;
  logic [W-1:0]    a_sh, b_sh, res_sh, res_next;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [NIBBLE_W-1:0] nib_sum;
  logic            nib_cout;
  logic            last;

  add4bit u_add4bit (nib_sum, nib_cout, a_sh[NIBBLE_W-1:0], b_sh[NIBBLE_W-1:0], carry);

  // New digit enters at the top so the low nibble ends up at bit 0 after NIBBLES shifts.
  assign res_next = W'({nib_sum, res_sh} >> NIBBLE_W);
  assign last     = (cnt == CW'(NIBBLES - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift registers are reset along with the control state; they are few flops, and it keeps
  // the datapath free of X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          res_sh <= res_next;
          carry  <= nib_cout;
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          cnt    <= cnt + CW'(1);
          // Outputs change only on the final digit, so they hold the old result throughout RUN.
          if (last) begin
            sum  <= res_next;
            cout <= nib_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add16_serial.sv
// Directed self-checking bench for add16_serial (NIBBLES=4).
module tb_add16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done;
  logic [15:0] sum;
  logic        cout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] prev;

  add16_serial #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call right after a negedge; returns on the negedge after the done cycle.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input string tag);
    logic [16:0] exp;
    int n;
    exp = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_runhold"}, {15'd0, cout, sum}, {15'd0, prev});
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 32'd5);
    check({tag, "_res"}, {15'd0, cout, sum}, {15'd0, exp});
    prev = exp;
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, {15'd0, cout, sum}, {15'd0, exp});
  endtask

  initial begin
    int n, ndone;
    logic [15:0] ta, tb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; prev = '0;
    @(negedge clk); @(negedge clk);
    check("rst_state", {13'd0, busy, done, cout}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0000, 1'b1, "ripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, "allones");

    // Start pulsed mid-RUN with other operands must be ignored.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        check("ign_res", {15'd0, cout, sum}, 32'h0000_3333);
      end
      @(negedge clk);
    end
    check("ign_ndone", ndone, 32'd1);
    check("ign_idle", {31'd0, busy}, 32'd0);
    prev = 17'h03333;

    // Reset during the second RUN cycle aborts immediately.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {30'd0, busy, done}, 32'd0);
    check("abort_sum", {15'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 32'd0);
    prev = '0;
    run_op(16'h00FF, 16'h0001, 1'b0, "after_abort");

    // Start held high: one result every NIBBLES+2 cycles.
    a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    check("b2b_first", {31'd0, done}, 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    start = 1'b0;
    check("b2b_period", n, 32'd6);
    check("b2b_res", {15'd0, cout, sum}, 32'h0000_0406);
    @(negedge clk);
    @(negedge clk);
    check("b2b_stop", {30'd0, busy, done}, 32'd0);
    prev = 17'h00406;

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ta = {12'($urandom), 4'(i)};
        tb = {12'($urandom), 4'(j)};
        run_op(ta, tb, 1'(i + j), "sweep");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add16_serial.md
ADD16_SERIAL -- requirements
Module: add16_serial

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit digits processed; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 a  input  W  operand A, captured on accepted start.
REQ-006 b  input  W  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse when result valid.
REQ-010 sum  output  W  result, held stable from done until the next accepted start.
REQ-011 cout  output  1  final carry-out, held with sum.

Function
REQ-012 States IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 -> capture a, b, cin into shift registers, clear nibble counter, go RUN; start=0 -> stay.
REQ-014 RUN: each cycle, feed low nibble of A, B and carry register to add4bit; shift the 4-bit sum into the top of the result register; store cout into the carry register; shift A and B right 4 bits; increment counter.
REQ-015 RUN -> DONE when counter reaches NIBBLES-1 in that cycle; exactly NIBBLES cycles in RUN.
REQ-016 DONE: done=1 for exactly one cycle, sum and cout valid; next state IDLE unconditionally.
REQ-017 Latency: start accepted at edge N -> done high during the cycle after edge N+NIBBLES (NIBBLES+1 edges start-to-done); next start acceptable in the cycle after done.
REQ-018 start while busy is ignored; captured operands are not disturbed by input changes during RUN.
REQ-019 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1); no saturation.
REQ-020 sum/cout updated only at DONE entry; during RUN, sum output shows the previous result.
REQ-021 Holding start high continuously yields back-to-back operations every NIBBLES+2 cycles.

Reset
REQ-022 rst=1 forces state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry register=0, independent of clk.
REQ-023 rst asserted mid-RUN aborts the operation; no done pulse is produced for it.
REQ-024 First start accepted on the first rising edge after rst deasserts.

Structure
REQ-025 State encoding (IDLE/RUN/DONE) and nibble width constant 4 belong in a shared package.
REQ-026 One sub-module instance: add4bit (ports sum, cout, a, b, cin, positional order as existing), purely combinational.
REQ-027 Counter width = clog2(NIBBLES), minimum 1 bit.

Verification
REQ-028 a=16'h1234, b=16'h4321, cin=0, start 1 cycle -> done after 5 edges, sum=16'h5555, cout=0.
REQ-029 a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1 (carry ripples through all four nibbles).
REQ-030 a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-031 start pulsed again during RUN with different a/b -> ignored; result matches first operands; one done only.
REQ-032 rst asserted in 2nd RUN cycle of a=16'h00FF, b=16'h0001 -> immediate busy=0, sum=0, no done; new start afterwards gives sum=16'h0100.
REQ-033 Exhaustive-style loop: a,b over 0..15 in low nibble plus random upper nibbles, cin toggled -> {cout,sum} equals a+b+cin for every operation.
